rr_arb_ctl: RTL and testbench

// - Round-robin arbiter/controller that shares one downstream resource (a cell-level datapath
//   or bus slot) between N requesters.
// - Forms the any-request OR-reduction of all requests.
// - Issues one registered one-hot grant at a time.
// - Holds the grant until the owner finishes, then rotates priority.
// - Sits between requester FSMs and the shared resource. Optional hold timeout bounds ownership.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 50 +++++
 rtl/rr_arb_ctl.sv | 123 ++++++++++++
 tb/tb_rr_arb_ctl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin arbiter slice.
//   state_t  : arbiter FSM state (IDLE, GRANT)
//   MAX_N    : largest supported requester count
//   clog2w() : index width for an N-entry vector, never less than 1 bit
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int MAX_N = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A 1- or 2-entry vector still needs a 1-bit index, so the width is clamped.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. It finds the first set request bit,
// scanning upward from the entry just after the previous owner and wrapping
// modulo N.
//
// Ports
//   req   in  [N-1:0]   request vector
//   last  in  [IW-1:0]  index of the previous owner (lowest priority)
//   valid out           at least one request is set
//   pick  out [IW-1:0]  index of the selected requester (0 when !valid)
//
// Method: {req, req} is shifted right by (last+1). The low N bits then hold
// the requests in priority order. A find-first on those bits, offset back by
// (last+1) modulo N, gives the absolute index.
// -----------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]           req,
  input  logic [clog2w(N)-1:0]   last,
  output logic                   valid,
  output logic [clog2w(N)-1:0]   pick
);

  localparam int IW = clog2w(N);

  int           start;
  logic [N-1:0] rot;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment. Otherwise the tool holds the old value and
  // infers a latch.
  always_comb begin
    start = (int'(last) >= N - 1) ? 0 : int'(last) + 1;
    rot   = N'({req, req} >> start);
    valid = |req;
    pick  = '0;
    // Scan downward so the lowest rotated position, which has the highest
    // priority, is the one left in pick at the end.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pick = IW'((i + start) % N);
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_arb_ctl.sv
// -----------------------------------------------------------------------------
// rr_arb_ctl
// Round-robin arbiter and controller that shares one downstream resource
// between N requesters. It issues one registered one-hot grant at a time and
// holds it until the owner finishes, drops its request, or reaches the
// optional hold limit. Priority then rotates past the released owner.
// There is always at least one idle cycle between two grants.
//
// Parameters
//   N         number of requesters, 2..8
//   MAX_HOLD  max consecutive grant cycles per ownership, 0 = unlimited
//   CW        hold-counter width, must be able to represent MAX_HOLD
//
// Ports
//   ck       in   clock, rising edge
//   nrst     in   asynchronous active-low reset
//   req      in   [N-1:0]   level request per requester
//   done     in   owner completion, sampled only while busy
//   gnt      out  [N-1:0]   registered one-hot grant, zero when idle
//   gnt_id   out  [IW-1:0]  binary index of the owner, valid while busy
//   busy     out  resource owned (equals |gnt)
//   any_req  out  combinational OR of req
//   timeout  out  one-cycle pulse in the cycle after a forced release
// -----------------------------------------------------------------------------
module rr_arb_ctl
  import arb_pkg::*;
#(
  parameter int N        = 3,
  parameter int MAX_HOLD = 4,
  parameter int CW       = 4
) (
  input  logic                   ck,
  input  logic                   nrst,
  input  logic [N-1:0]           req,
  input  logic                   done,
  output logic [N-1:0]           gnt,
  output logic [clog2w(N)-1:0]   gnt_id,
  output logic                   busy,
  output logic                   any_req,
  output logic                   timeout
);

  localparam int IW = clog2w(N);

  // With no hold limit the counter only has to avoid wrapping, so it
  // saturates at all-ones.
  localparam logic [CW-1:0] CNT_SAT = (MAX_HOLD != 0) ? CW'(MAX_HOLD) : '1;

  state_t          state;
  logic [IW-1:0]   last;
  logic [CW-1:0]   cnt;

  logic            pick_valid;
  logic [IW-1:0]   pick;
  logic            owner_req;
  logic            expired;
  logic            release_now;

  assign any_req = |req;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .pick  (pick)
  );

  // Release conditions, in priority order: done, owner dropped its request,
  // hold limit reached. A timeout is reported only when the hold limit is
  // the sole reason for the release.
  assign owner_req   = req[gnt_id];
  assign expired     = (MAX_HOLD != 0) && (cnt == CW'(MAX_HOLD));
  assign release_now = done || !owner_req || expired;

  // NOTE: state registers use non-blocking assignments. Every register then
  // samples values from before the edge, whatever order the statements are
  // written in.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      last    <= IW'(N - 1);   // req[0] wins the first arbitration
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state  <= GRANT;
            gnt    <= N'(1) << pick;
            gnt_id <= pick;
            busy   <= 1'b1;
            cnt    <= CW'(1);
          end
        end
        GRANT: begin
          if (release_now) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            last    <= gnt_id;
            timeout <= !done && owner_req && expired;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The grant must never name more than one requester.
  a_gnt_onehot0 : assert property (@(posedge ck) disable iff (!nrst) $onehot0(gnt));

endmodule : rr_arb_ctl

// File: tb/tb_rr_arb_ctl.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_ctl
// Self-checking bench for rr_arb_ctl with N=3 and MAX_HOLD=4. The reference
// model tracks the owner as an integer (-1 when idle), the previous owner,
// and a hold count. It picks the next owner by scanning (last+k) mod N.
// Directed scenarios cover the documented sequences. A randomized run
// follows and is checked against the same model.
// -----------------------------------------------------------------------------
module tb_rr_arb_ctl;

  localparam int N        = 3;
  localparam int MAX_HOLD = 4;
  localparam int CW       = 4;
  localparam int IW       = 2;

  logic          ck;
  logic          nrst;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          any_req;
  logic          timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_to;

  rr_arb_ctl #(.N(N), .MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .ck      (ck),
    .nrst    (nrst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .any_req (any_req),
    .timeout (timeout)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_cnt   = 0;
    m_to    = 1'b0;
  endtask

  // Advance the model by one clock edge, using the inputs present at the edge.
  task automatic model_edge(input logic [N-1:0] r, input logic d);
    m_to = 1'b0;
    if (m_owner < 0) begin
      m_owner = model_pick(r, m_last);
      if (m_owner >= 0) m_cnt = 1;
    end else if (d || !r[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD) begin
      m_last  = m_owner;
      m_owner = -1;
      m_to    = 1'b1;
    end else if (m_cnt < MAX_HOLD || MAX_HOLD == 0) begin
      m_cnt++;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [N-1:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? '0 : N'(1) << m_owner;
    check({tag, ".gnt"},     32'(gnt),     32'(exp_gnt));
    check({tag, ".busy"},    32'(busy),    32'(m_owner >= 0));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    if (m_owner >= 0) check({tag, ".gnt_id"}, 32'(gnt_id), 32'(m_owner));
  endtask

  // Apply inputs, check any_req, take one edge, then check against the model.
  task automatic step(input string tag, input logic [N-1:0] r, input logic d);
    req  = r;
    done = d;
    #1;
    check({tag, ".any_req"}, 32'(any_req), 32'(|r));
    @(posedge ck);
    model_edge(r, d);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    @(negedge ck);
    req  = '0;
    done = 1'b0;
    nrst = 1'b0;
    #2;
    model_reset();
    check("rst.gnt",     32'(gnt),     32'd0);
    check("rst.gnt_id",  32'(gnt_id),  32'd0);
    check("rst.busy",    32'(busy),    32'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    @(negedge ck);
    nrst = 1'b1;
    @(posedge ck);
    #1;
  endtask

  logic [N-1:0] rot_exp [7];
  logic [N-1:0] to_gnt  [6];
  logic         to_flag [6];
  logic [N-1:0] r_rand;

  initial begin
    nrst = 1'b0;
    req  = '0;
    done = 1'b0;
    model_reset();

    // 1. Rotation with done asserted throughout the grant.
    rot_exp = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step("rot", 3'b111, 1'b1);
      check($sformatf("rot.seq%0d", i), 32'(gnt), 32'(rot_exp[i]));
    end

    // 2. Single requester.
    do_reset();
    step("single", 3'b010, 1'b0);
    check("single.gnt",    32'(gnt),    32'b010);
    check("single.gnt_id", 32'(gnt_id), 32'd1);
    check("single.busy",   32'(busy),   32'd1);

    // 3. Timeout on a lone requester, followed by a re-grant.
    to_gnt  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001};
    to_flag = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step("tmo", 3'b001, 1'b0);
      check($sformatf("tmo.gnt%0d", i), 32'(gnt),     32'(to_gnt[i]));
      check($sformatf("tmo.to%0d", i),  32'(timeout), 32'(to_flag[i]));
    end

    // 4. Owner 2 drops its request while req[0] is pending.
    do_reset();
    step("drop", 3'b100, 1'b0);
    check("drop.own", 32'(gnt), 32'b100);
    step("drop", 3'b001, 1'b0);
    check("drop.rel", 32'(gnt), 32'b000);
    step("drop", 3'b001, 1'b0);
    check("drop.next", 32'(gnt), 32'b001);

    // 5. Asynchronous reset in the middle of a grant to requester 2.
    do_reset();
    step("arst", 3'b100, 1'b0);
    check("arst.own", 32'(gnt), 32'b100);
    #2;
    nrst = 1'b0;
    #1;
    check("arst.gnt_async",  32'(gnt),  32'd0);
    check("arst.busy_async", 32'(busy), 32'd0);
    model_reset();
    @(negedge ck);
    nrst = 1'b1;
    step("arst", 3'b111, 1'b0);
    check("arst.first", 32'(gnt), 32'b001);

    // 6. done on the same edge that the hold limit is reached.
    do_reset();
    step("dexp", 3'b001, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) step("dexp", 3'b001, 1'b0);
    step("dexp", 3'b001, 1'b1);
    check("dexp.gnt", 32'(gnt),     32'd0);
    check("dexp.to",  32'(timeout), 32'd0);

    // Randomized traffic: sticky request bits, occasional done pulses.
    do_reset();
    r_rand = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) r_rand[b] = ~r_rand[b];
      end
      step("rand", r_rand, ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rr_arb_ctl
